// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single data-memory port between the core mem stage (requester 0)
//   and a debug/DMA master (requester 1). One request is accepted at a time via
//   a valid/ready handshake with round-robin tie-breaking. The accepted request
//   becomes a registered one-cycle memory command; reads then wait
//   READ_LATENCY cycles and the returned data is registered back to the
//   requester that issued it.
//
// Parameters:
//   READ_LATENCY  cycles from the command cycle until i_dmem_rdata is valid
//                 (legal range 1..7)
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-low reset
//   i_rN_valid / o_rN_ready      requester N handshake (N = 0, 1)
//   i_rN_addr/ren/wen/wdata/mask requester N command fields
//   o_rN_rvalid / o_rN_rdata     requester N read return (one-cycle pulse)
//   o_dmem_addr/ren/wen/wdata/mask  registered memory command
//   i_dmem_rdata                 memory read data
//   o_busy                       arbiter is not idle
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_r0_valid,
    output logic        o_r0_ready,
    input  logic [31:0] i_r0_addr,
    input  logic        i_r0_ren,
    input  logic        i_r0_wen,
    input  logic [31:0] i_r0_wdata,
    input  logic [3:0]  i_r0_mask,
    output logic        o_r0_rvalid,
    output logic [31:0] o_r0_rdata,

    input  logic        i_r1_valid,
    output logic        o_r1_ready,
    input  logic [31:0] i_r1_addr,
    input  logic        i_r1_ren,
    input  logic        i_r1_wen,
    input  logic [31:0] i_r1_wdata,
    input  logic [3:0]  i_r1_mask,
    output logic        o_r1_rvalid,
    output logic [31:0] o_r1_rdata,

    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_ren,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic [31:0] i_dmem_rdata,

    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT
    } state_t;

    localparam logic [2:0] LP_LATENCY = 3'(READ_LATENCY);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_last_served;
    logic        r_owner;
    logic [2:0]  r_cnt;

    logic [31:0] r_dmem_addr;
    logic        r_dmem_ren;
    logic        r_dmem_wen;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_mask;

    logic        r_r0_rvalid;
    logic [31:0] r_r0_rdata;
    logic        r_r1_rvalid;
    logic [31:0] r_r1_rdata;

    logic        w_r0_ready;
    logic        w_r1_ready;
    logic        w_busy;
    logic        w_accept;
    logic        w_acc_owner;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_acc_mask;
    logic        w_acc_ren;
    logic        w_acc_wen;
    logic        w_rd_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_CMD;
            // r_dmem_ren is only ever set for a pure read, so it doubles as
            // the captured "this command is a read" flag.
            ST_CMD:  w_next_state = r_dmem_ren ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (r_cnt == 3'd1) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (grant and busy)
    // ------------------------------------------------------------------
    always_comb begin
        w_r0_ready = 1'b0;
        w_r1_ready = 1'b0;
        w_busy     = 1'b1;
        if (r_state == ST_IDLE) begin
            w_busy = 1'b0;
            // On a tie the requester that was not served last wins.
            w_r0_ready = i_r0_valid && (!i_r1_valid ||  r_last_served);
            w_r1_ready = i_r1_valid && (!i_r0_valid || !r_last_served);
        end
    end

    assign w_accept    = w_r0_ready || w_r1_ready;
    assign w_acc_owner = w_r1_ready;
    assign w_acc_addr  = w_acc_owner ? i_r1_addr  : i_r0_addr;
    assign w_acc_wdata = w_acc_owner ? i_r1_wdata : i_r0_wdata;
    assign w_acc_mask  = w_acc_owner ? i_r1_mask  : i_r0_mask;
    assign w_acc_ren   = w_acc_owner ? i_r1_ren   : i_r0_ren;
    assign w_acc_wen   = w_acc_owner ? i_r1_wen   : i_r0_wen;

    assign w_rd_done   = (r_state == ST_WAIT) && (r_cnt == 3'd1);

    // ------------------------------------------------------------------
    // Datapath: command capture, latency counter, read return
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last_served <= 1'b1;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            r_dmem_addr   <= '0;
            r_dmem_ren    <= 1'b0;
            r_dmem_wen    <= 1'b0;
            r_dmem_wdata  <= '0;
            r_dmem_mask   <= '0;
            r_r0_rvalid   <= 1'b0;
            r_r0_rdata    <= '0;
            r_r1_rvalid   <= 1'b0;
            r_r1_rdata    <= '0;
        end else begin
            // Strobes and rvalid are single-cycle pulses.
            r_dmem_ren  <= 1'b0;
            r_dmem_wen  <= 1'b0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;

            if (w_accept) begin
                r_last_served <= w_acc_owner;
                r_owner       <= w_acc_owner;
                r_dmem_addr   <= w_acc_addr;
                r_dmem_wdata  <= w_acc_wdata;
                r_dmem_mask   <= w_acc_mask;
                // Write has priority when both ren and wen are set.
                r_dmem_wen    <= w_acc_wen;
                r_dmem_ren    <= w_acc_ren && !w_acc_wen;
            end

            if ((r_state == ST_CMD) && r_dmem_ren) begin
                r_cnt <= LP_LATENCY;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_rd_done) begin
                if (r_owner) begin
                    r_r1_rdata  <= i_dmem_rdata;
                    r_r1_rvalid <= 1'b1;
                end else begin
                    r_r0_rdata  <= i_dmem_rdata;
                    r_r0_rvalid <= 1'b1;
                end
            end
        end
    end

    assign o_r0_ready   = w_r0_ready;
    assign o_r1_ready   = w_r1_ready;
    assign o_busy       = w_busy;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_ren   = r_dmem_ren;
    assign o_dmem_wen   = r_dmem_wen;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_dmem_mask  = r_dmem_mask;
    assign o_r0_rvalid  = r_r0_rvalid;
    assign o_r0_rdata   = r_r0_rdata;
    assign o_r1_rvalid  = r_r1_rvalid;
    assign o_r1_rdata   = r_r1_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Two arbiters (READ_LATENCY = 1 and 4) driven with independent randomized
// traffic. A transaction-level timeline model predicts, per cycle, the grant,
// the command cycle, the cycle the arbiter becomes free again and the cycle
// read data returns, and every DUT output is compared against it.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int HIST = 1024;

    typedef struct packed {
        logic        valid;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    logic        clk;
    logic        rst_n;

    req_t        req    [2][2];   // [dut][requester]
    logic        rdy    [2][2];
    logic        rv     [2][2];
    logic [31:0] rdat   [2][2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata[2];
    logic [31:0] d_rdata[2];
    logic        d_ren  [2];
    logic        d_wen  [2];
    logic [3:0]  d_mask [2];
    logic        busy   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_port_arbiter #(
            .READ_LATENCY((g == 0) ? 1 : 4)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst_n),
            .i_r0_valid   (req[g][0].valid),
            .o_r0_ready   (rdy[g][0]),
            .i_r0_addr    (req[g][0].addr),
            .i_r0_ren     (req[g][0].ren),
            .i_r0_wen     (req[g][0].wen),
            .i_r0_wdata   (req[g][0].wdata),
            .i_r0_mask    (req[g][0].mask),
            .o_r0_rvalid  (rv[g][0]),
            .o_r0_rdata   (rdat[g][0]),
            .i_r1_valid   (req[g][1].valid),
            .o_r1_ready   (rdy[g][1]),
            .i_r1_addr    (req[g][1].addr),
            .i_r1_ren     (req[g][1].ren),
            .i_r1_wen     (req[g][1].wen),
            .i_r1_wdata   (req[g][1].wdata),
            .i_r1_mask    (req[g][1].mask),
            .o_r1_rvalid  (rv[g][1]),
            .o_r1_rdata   (rdat[g][1]),
            .o_dmem_addr  (d_addr[g]),
            .o_dmem_ren   (d_ren[g]),
            .o_dmem_wen   (d_wen[g]),
            .o_dmem_wdata (d_wdata[g]),
            .o_dmem_mask  (d_mask[g]),
            .i_dmem_rdata (d_rdata[g]),
            .o_busy       (busy[g])
        );
    end

    // Reference model: timeline of the current/last transaction per DUT.
    int          rl      [2];
    int          cyc;
    int          free_at [2];   // first cycle a new request may be accepted
    int          cmd_cyc [2];   // cycle the memory command is on the bus
    int          rv_cyc  [2];   // cycle read data returns
    int          rv_own  [2];
    logic        last    [2];
    logic        m_rd    [2];
    logic        m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_mask  [2];
    logic [31:0] m_rdata [2][2];
    logic [31:0] hist    [2][HIST];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed 0x%08h expected 0x%08h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0;
            cmd_cyc[k] = -1;
            rv_cyc[k]  = -1;
            rv_own[k]  = 0;
            last[k]    = 1'b1;
            m_rd[k]    = 1'b0;
            m_wr[k]    = 1'b0;
            m_addr[k]  = '0;
            m_wdata[k] = '0;
            m_mask[k]  = '0;
            m_rdata[k][0] = '0;
            m_rdata[k][1] = '0;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            req[k][0] = '0;
            req[k][1] = '0;
            d_rdata[k] = '0;
        end
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",  k, busy[k],    0);
            chk("rst_ren",   k, d_ren[k],   0);
            chk("rst_wen",   k, d_wen[k],   0);
            chk("rst_addr",  k, d_addr[k],  0);
            chk("rst_wdata", k, d_wdata[k], 0);
            chk("rst_mask",  k, d_mask[k],  0);
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("rst_r%0d_rvalid", r), k, rv[k][r],   0);
                chk($sformatf("rst_r%0d_rdata", r),  k, rdat[k][r], 0);
                chk($sformatf("rst_r%0d_ready", r),  k, rdy[k][r],  0);
            end
        end
    endtask

    // One clock cycle: check registered outputs, drive new inputs, check
    // grant, advance the model. contend = 1 keeps both requesters valid.
    task automatic cycle(input bit contend);
        int   g;
        req_t q;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (cyc == rv_cyc[k]) m_rdata[k][rv_own[k]] = hist[k][(cyc - 1) % HIST];
            chk("busy",  k, busy[k],  32'(cyc < free_at[k]));
            chk("ren",   k, d_ren[k], 32'(cyc == cmd_cyc[k] && m_rd[k]));
            chk("wen",   k, d_wen[k], 32'(cyc == cmd_cyc[k] && m_wr[k]));
            chk("addr",  k, d_addr[k],  m_addr[k]);
            chk("wdata", k, d_wdata[k], m_wdata[k]);
            chk("mask",  k, d_mask[k],  m_mask[k]);
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("r%0d_rvalid", r), k, rv[k][r],
                    32'(cyc == rv_cyc[k] && rv_own[k] == r));
                chk($sformatf("r%0d_rdata", r), k, rdat[k][r], m_rdata[k][r]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                req[k][r].valid = contend ? 1'b1 : 1'($urandom_range(0, 1));
                req[k][r].ren   = 1'($urandom_range(0, 1));
                req[k][r].wen   = 1'($urandom_range(0, 1));
                req[k][r].addr  = $urandom;
                req[k][r].wdata = $urandom;
                req[k][r].mask  = 4'($urandom_range(0, 15));
            end
            d_rdata[k] = $urandom;
            hist[k][cyc % HIST] = d_rdata[k];
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            g = -1;
            if (cyc >= free_at[k]) begin
                if (req[k][0].valid && req[k][1].valid) g = last[k] ? 0 : 1;
                else if (req[k][0].valid)               g = 0;
                else if (req[k][1].valid)               g = 1;
            end
            chk("r0_ready", k, rdy[k][0], 32'(g == 0));
            chk("r1_ready", k, rdy[k][1], 32'(g == 1));
            if (g >= 0) begin
                q          = req[k][g];
                last[k]    = (g == 1);
                m_wr[k]    = q.wen;
                m_rd[k]    = q.ren && !q.wen;
                m_addr[k]  = q.addr;
                m_wdata[k] = q.wdata;
                m_mask[k]  = q.mask;
                cmd_cyc[k] = cyc + 1;
                if (m_rd[k]) begin
                    free_at[k] = cyc + rl[k] + 2;
                    rv_cyc[k]  = cyc + rl[k] + 2;
                    rv_own[k]  = g;
                end else begin
                    free_at[k] = cyc + 2;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        bit found;
        n_vec = 0;
        n_err = 0;
        rl[0] = 1;
        rl[1] = 4;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_reset_values();
        model_reset();

        repeat (24)  cycle(1'b1);
        repeat (600) cycle(1'b0);

        // Reset in the middle of a READ_LATENCY = 4 read.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(1'b0);
            if (m_rd[1] && cyc > cmd_cyc[1] && cyc < free_at[1]) found = 1'b1;
        end
        chk("reach_wait_state", 1, 32'(found), 1);
        @(posedge clk);
        #2;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_reset_values();
        model_reset();

        repeat (24)  cycle(1'b1);
        repeat (150) cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
